bus_mem_io: RTL and testbench

- Memory/peripheral responder on the cpu6502 external bus: the device side of the addr/idata/odata/rw/clk2 interface that the CPU drives.
- Provides RAM, a reset-vector pair, and a memory-mapped I/O page with a 16-bit down-counter timer that drives the CPU's active-low irq.
- Instantiated next to cpu6502 in system builds and CPU tests in place of ad-hoc ROM stubs.

---
 rtl/bus_mem_io.sv | 149 ++++++++++++++
 tb/tb_bus_mem_io.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_io.sv
// Purpose: device side of the cpu6502 external bus: RAM, reset vector, I/O page with a 16-bit timer.
// Latency: reads are combinational from addr; writes and timer ticks commit on the clk after phi2 falls.
// Backpressure: none; the CPU bus has no wait states, so every access completes in its phi2 cycle.
//
// Ports:
//   clk    system clock shared with cpu6502
//   reset  asynchronous active-low reset
//   addr   CPU address bus          odata  CPU write data
//   rw     1 = read, 0 = write      clk2   CPU phi2
//   idata  read data to the CPU     irq    active-low timer interrupt
//   nmi    active-low NMI, held inactive
module bus_mem_io #(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] IO_BASE   = 16'h4400,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  odata,
  input  logic        rw,
  input  logic        clk2,
  output logic [7:0]  idata,
  output logic        irq,
  output logic        nmi
);

  typedef enum logic {IDLE, RUN} tstate_t;

  tstate_t     state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        expired_q, expired_d;
  logic        expire_evt;
  logic [7:0]  tlo_q, thi_q, ctrl_q, scr0_q, scr1_q;
  logic        clk2_q;
  logic        irq_q;

  logic        phi2_end;
  logic        ram_sel, io_sel, wr_en;
  logic        wr_tlo, wr_thi, wr_stat, wr_ctrl, wr_scr0, wr_scr1;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];

  // Bus cycles end on the falling edge of phi2; this is the single commit point.
  assign phi2_end = clk2_q & ~clk2;
  assign ram_sel  = ((32'(addr) >> RAM_AW) == 32'd0);
  assign io_sel   = ~ram_sel && (addr[15:3] == IO_BASE[15:3]);
  assign wr_en    = phi2_end & ~rw;

  assign wr_tlo  = wr_en & io_sel & (addr[2:0] == 3'd0);
  assign wr_thi  = wr_en & io_sel & (addr[2:0] == 3'd1);
  assign wr_stat = wr_en & io_sel & (addr[2:0] == 3'd2);
  assign wr_ctrl = wr_en & io_sel & (addr[2:0] == 3'd3);
  assign wr_scr0 = wr_en & io_sel & (addr[2:0] == 3'd6);
  assign wr_scr1 = wr_en & io_sel & (addr[2:0] == 3'd7);

  // RAM is deliberately not reset so program images survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) begin
      ram[addr[RAM_AW-1:0]] <= odata;
    end
  end

  // Timer next-state. Order of the three blocks encodes the collision rules:
  // the tick uses the current (old) ctrl_q, a STAT clear loses to a same-cycle
  // expiry, and a THI write overrides everything the tick decided.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    expired_d  = expired_q;
    expire_evt = 1'b0;
    if (phi2_end && state_q == RUN) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expire_evt = 1'b1;
        expired_d  = 1'b1;
        if (ctrl_q[1]) begin
          count_d = {thi_q, tlo_q};
        end else begin
          state_d = IDLE;
          count_d = 16'd0;
        end
      end
    end
    if (wr_stat && odata[0] && !expire_evt) begin
      expired_d = 1'b0;
    end
    if (wr_thi) begin
      count_d   = {odata, tlo_q};
      state_d   = RUN;
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 16'd0;
      expired_q <= 1'b0;
      tlo_q     <= 8'd0;
      thi_q     <= 8'd0;
      ctrl_q    <= 8'd0;
      scr0_q    <= 8'd0;
      scr1_q    <= 8'd0;
      clk2_q    <= 1'b0;
      irq_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      clk2_q    <= clk2;
      // Registered from current state, so irq trails expired/irq_en by one clk.
      irq_q     <= ~(expired_q & ctrl_q[0]);
      if (wr_tlo)  tlo_q  <= odata;
      if (wr_thi)  thi_q  <= odata;
      if (wr_ctrl) ctrl_q <= odata;
      if (wr_scr0) scr0_q <= odata;
      if (wr_scr1) scr1_q <= odata;
    end
  end

  // Read path: pure decode of addr, no side effects.
  always_comb begin
    idata = 8'h00;
    if (ram_sel) begin
      idata = ram[addr[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (addr[2:0])
        3'd0:    idata = tlo_q;
        3'd1:    idata = thi_q;
        3'd2:    idata = {6'd0, (state_q == RUN), expired_q};
        3'd3:    idata = ctrl_q;
        3'd4:    idata = count_q[7:0];
        3'd5:    idata = count_q[15:8];
        3'd6:    idata = scr0_q;
        default: idata = scr1_q;
      endcase
    end else if (addr == 16'hFFFC) begin
      idata = RESET_VEC[7:0];
    end else if (addr == 16'hFFFD) begin
      idata = RESET_VEC[15:8];
    end
  end

  assign irq = irq_q;
  assign nmi = 1'b1;

endmodule

// File: tb/tb_bus_mem_io.sv
// Purpose: scoreboard bench for bus_mem_io; stimulus queues expected values, a monitor compares.
// Latency: monitor samples on the falling clk edge while chk_vld is high.
// Backpressure: none; every queued expectation is consumed by the next monitor sample.
module tb_bus_mem_io;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  odata;
  logic        rw;
  logic        clk2;
  logic [7:0]  idata;
  logic        irq;
  logic        nmi;

  logic        chk_vld;
  logic [9:0]  exp_q [$];
  string       name_q [$];
  int          checks;
  int          errors;

  logic [9:0]  m_e;
  logic [7:0]  m_act;
  string       m_n;

  localparam logic [15:0] TLO  = 16'h4400;
  localparam logic [15:0] THI  = 16'h4401;
  localparam logic [15:0] STAT = 16'h4402;
  localparam logic [15:0] CTRL = 16'h4403;
  localparam logic [15:0] CNTL = 16'h4404;
  localparam logic [15:0] CNTH = 16'h4405;
  localparam logic [15:0] NONE = 16'h8000;

  bus_mem_io #(.RAM_AW(10), .IO_BASE(16'h4400), .RESET_VEC(16'h1234)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .odata (odata),
    .rw    (rw),
    .clk2  (clk2),
    .idata (idata),
    .irq   (irq),
    .nmi   (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation per sample and compares.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: sample with no expectation queued");
      end else begin
        m_e = exp_q.pop_front();
        m_n = name_q.pop_front();
        case (m_e[9:8])
          2'd0:    m_act = idata;
          2'd1:    m_act = {7'd0, irq};
          default: m_act = {7'd0, nmi};
        endcase
        checks++;
        if (m_act !== m_e[7:0]) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", m_n, m_act, m_e[7:0]);
        end
      end
    end
  end

  // One phi2 cycle: high for two clks, low, ending just after the commit edge.
  task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic r);
    addr  = a;
    odata = d;
    rw    = r;
    clk2  = 1'b1;
    repeat (2) @(posedge clk);
    #1 clk2 = 1'b0;
    @(posedge clk);
    #1 rw = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    tick(a, d, 1'b0);
  endtask

  task automatic idle_tick();
    tick(NONE, 8'h00, 1'b1);
  endtask

  task automatic chk(input logic [1:0] k, input logic [7:0] e, input string n);
    exp_q.push_back({k, e});
    name_q.push_back(n);
    chk_vld = 1'b1;
    @(posedge clk);
    #1 chk_vld = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
    addr = a;
    rw   = 1'b1;
    chk(2'd0, e, n);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    clk2    = 1'b0;
    addr    = 16'h0000;
    odata   = 8'h00;
    rw      = 1'b1;
    chk_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    chk(2'd1, 8'h01, "rst_irq");
    chk(2'd2, 8'h01, "rst_nmi");
    rd(STAT, 8'h00, "rst_stat");
    rd(TLO,  8'h00, "rst_tlo");
    rd(CTRL, 8'h00, "rst_ctrl");
    rd(CNTL, 8'h00, "rst_cntl");

    // Vector and unmapped reads
    rd(16'hFFFC, 8'h34, "vec_lo");
    rd(16'hFFFD, 8'h12, "vec_hi");
    rd(NONE,     8'h00, "unmapped");

    // RAM and ignored writes
    wr(16'h0099, 8'hC3);
    rd(16'h0099, 8'hC3, "ram_wr");
    tick(16'h0099, 8'h5A, 1'b1);
    rd(16'h0099, 8'hC3, "ram_rw1_nowrite");
    wr(16'hFFFC, 8'h77);
    rd(16'hFFFC, 8'h34, "vec_wr_ignored");
    wr(16'h4406, 8'hA5);
    rd(16'h4406, 8'hA5, "scr0");
    wr(16'h4407, 8'h3C);
    rd(16'h4407, 8'h3C, "scr1");
    wr(CTRL, 8'hF0);
    rd(CTRL, 8'hF0, "ctrl_upper_bits");
    wr(CNTL, 8'h99);
    rd(CNTL, 8'h00, "cntl_readonly");

    // One-shot: reload 3, expires on the 4th phi2_end
    wr(CTRL, 8'h01);
    wr(TLO,  8'h03);
    wr(THI,  8'h00);
    rd(STAT, 8'h02, "os_running");
    rd(CNTL, 8'h03, "os_loaded");
    idle_tick();
    idle_tick();
    idle_tick();
    chk(2'd1, 8'h01, "os_irq_3ticks");
    rd(CNTL, 8'h00, "os_cnt_zero");
    rd(STAT, 8'h02, "os_not_expired");
    idle_tick();
    chk(2'd1, 8'h01, "os_irq_lag");
    chk(2'd1, 8'h00, "os_irq_set");
    rd(STAT, 8'h01, "os_stat_expired");
    rd(CNTL, 8'h00, "os_cnt_hold");

    // Auto-reload: reload 2, expiry every 3 phi2_end
    wr(CTRL, 8'h03);
    wr(TLO,  8'h02);
    wr(THI,  8'h00);
    rd(STAT, 8'h02, "ar_thi_clears");
    idle_tick();
    idle_tick();
    rd(STAT, 8'h02, "ar_before_exp");
    idle_tick();
    rd(STAT, 8'h03, "ar_expired");
    rd(CNTL, 8'h02, "ar_reloaded");
    chk(2'd1, 8'h00, "ar_irq_low");
    wr(STAT, 8'h01);
    rd(STAT, 8'h02, "ar_cleared");
    chk(2'd1, 8'h01, "ar_irq_high");
    idle_tick();
    rd(STAT, 8'h02, "ar_period_pre");
    idle_tick();
    rd(STAT, 8'h03, "ar_period_exp");

    // Collision: THI write on the expiry phi2_end
    wr(STAT, 8'h01);
    wr(TLO,  8'h05);
    wr(THI,  8'h01);
    rd(STAT, 8'h02, "coll_stat");
    rd(CNTL, 8'h05, "coll_cntl");
    rd(CNTH, 8'h01, "coll_cnth");
    chk(2'd1, 8'h01, "coll_irq");

    // Reset mid-count, observed before any further rising edge
    wr(TLO, 8'h50);
    wr(THI, 8'h00);
    rd(CNTL, 8'h50, "pre_rst_cnt");
    addr  = STAT;
    reset = 1'b0;
    chk(2'd0, 8'h00, "midrst_stat");
    rd(CNTL, 8'h00, "midrst_cntl");
    chk(2'd1, 8'h01, "midrst_irq");
    #1 reset = 1'b1;
    rd(16'h0099, 8'hC3, "ram_survives_rst");
    rd(TLO, 8'h00, "tlo_after_rst");
    idle_tick();
    rd(STAT, 8'h00, "idle_after_rst");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
